mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- E-stage multiply/divide unit owning the HI/LO registers.
- Executes mult, multu, div, divu and msub over a fixed multi-cycle latency; executes mthi/mtlo in one cycle.
- Produces the Busy signal consumed by the pipeline stall controller, which freezes PC/D and bubbles E while Busy is high and the D-stage instruction is a HI/LO-class op.
- HI/LO outputs feed the mfhi/mflo result path in E.

Parameters:
MULT_CYCLES, 5, busy cycles after issue for mult/multu/msub (legal range 1..15)
DIV_CYCLES, 10, busy cycles after issue for div/divu (legal range 1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Start  input  1  issue strobe from E-stage decode, one cycle per instruction
MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 msub
A  input  32  forwarded rs value in E
B  input  32  forwarded rt value in E
Cancel  input  1  abort in-flight op (present only with MDU_CANCEL_EN)
Busy  output  1  Start issuing a multi-cycle op, or busy_q
HI  output  32  architectural HI
LO  output  32  architectural LO

Behaviour:
- Reset at a clock edge with reset=1: HI=0, LO=0, busy_q=0, counter=0, pending result=0. Busy=0 while reset is high. Reset overrides everything, including an in-flight op, which is discarded.
- State machine has two states:
  - IDLE, busy_q=0.
  - RUN, busy_q=1, with a 4-bit down-counter.
- Issue (IDLE, Start=1, MDOp in {1,2,3,4,7}), edge at end of cycle T:
  - Capture the result into pending registers, computed from A/B (and current HI/LO for msub).
  - Load counter with MULT_CYCLES or DIV_CYCLES and enter RUN.
  - Busy is high combinationally during T (so the dependent instruction in D stalls immediately) and for cycles T+1..T+N, i.e. N+1 cycles total.
- RUN: counter decrements each edge. On the edge where counter==1, commit pending to HI/LO and return to IDLE. A new HI/LO value is first visible in cycle T+N+1.
- mthi/mtlo (IDLE, Start=1, MDOp 5/6): HI<=A or LO<=A at the end of cycle T. Busy is not asserted.
- Start with MDOp=0 is a no-op.
- Start while in RUN: ignored entirely; no write, no restart. The stall controller guarantees this does not occur.
- Arithmetic:
  - mult: {HI,LO} = signed A × signed B, 64-bit.
  - multu: same as mult, unsigned.
  - msub: {HI,LO} = {HI,LO} − (signed A × signed B), 64-bit wrap-around. HI/LO are sampled at issue.
  - div: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (div or divu with B=0): enters RUN for DIV_CYCLES as normal; HI/LO unchanged at commit.
- HI/LO outputs change only at commit, on mthi/mtlo, or at reset. They are never combinational from A/B.

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined:
  - Cancel port exists.
  - Cancel=1 in RUN: return to IDLE at that edge, discard pending, leave HI/LO unchanged. busy_q=0 from the next cycle.
  - Cancel=1 in the same cycle as Start: suppresses the issue, including mthi/mtlo writes.
  - Cancel has priority over commit on the final edge.
- Undefined: no Cancel port; every issued op always commits.

Test Plan:
1. reset, then issue mult A=0xFFFFFFFE, B=3 -> Busy high for 6 cycles (T..T+5); HI=0xFFFFFFFF, LO=0xFFFFFFFA in cycle T+6; HI/LO unchanged before that.
2. div A=0xFFFFFFF9 (−7), B=2 -> Busy high 11 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu same operands -> LO=0x7FFFFFFC, HI=1.
3. mthi A=0x00000010, mtlo A=0x00000020, then msub A=2, B=3 -> HI=0x00000010, LO=0x0000001A.
4. divu B=0 after mtlo 0x1234 -> Busy high 11 cycles; LO stays 0x1234.
5. Issue multu 0xFFFFFFFF×0xFFFFFFFF; Start with mthi at T+2; reset at T+3 -> mthi ignored; at T+4 HI=0, LO=0, Busy=0, no later commit.
6. (MDU_CANCEL_EN) issue div 100/7, then Cancel at T+4 -> Busy low from T+5; HI/LO keep their prior values.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit owning the HI/LO registers.
// Multi-cycle ops (mult, multu, div, divu, msub) compute their result at issue, hold it in
// pending registers and commit it to HI/LO after a fixed latency; mthi/mtlo write in one cycle.
// Optional feature: define MDU_CANCEL_EN to add the Cancel port, which aborts an in-flight op
// and suppresses a same-cycle issue.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
`ifdef MDU_CANCEL_EN
    input  logic        Cancel,
`endif
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;
    localparam logic [2:0] OpMsub  = 3'd7;

    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;

    logic        cancel;
    logic        is_multi;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [63:0]        msub_res;
    logic [31:0]        div_sb, div_ub;
    logic [31:0]        quot_s, rem_s, quot_u, rem_u;

`ifdef MDU_CANCEL_EN
    assign cancel = Cancel;
`else
    assign cancel = 1'b0;
`endif

    // Datapath: all candidate results are formed combinationally from the issue-cycle operands.
    always_comb begin
        prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u   = {32'd0, A} * {32'd0, B};
        msub_res = {hi_q, lo_q} - $unsigned(prod_s);
        // A zero divisor is never committed, and 0x80000000 / -1 equals 0x80000000 / 1, so
        // substituting 1 keeps the dividers free of trap cases without a separate result mux.
        div_sb   = ((B == 32'd0) || ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)))
                   ? 32'd1 : B;
        div_ub   = (B == 32'd0) ? 32'd1 : B;
        quot_s   = $signed(A) / $signed(div_sb);
        rem_s    = $signed(A) % $signed(div_sb);
        quot_u   = A / div_ub;
        rem_u    = A % div_ub;
        is_multi = (MDOp == OpMult) || (MDOp == OpMultu) || (MDOp == OpDiv) ||
                   (MDOp == OpDivu) || (MDOp == OpMsub);
    end

    // Next-state logic: issue from IDLE, count down in RUN, commit or cancel at the end.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        unique case (state_q)
            StIdle: begin
                if (Start && !cancel) begin
                    case (MDOp)
                        OpMult: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_we_d = 1'b1;
                            cnt_d     = MultLoad;
                            state_d   = StRun;
                        end
                        OpMultu: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_we_d = 1'b1;
                            cnt_d     = MultLoad;
                            state_d   = StRun;
                        end
                        OpMsub: begin
                            {pend_hi_d, pend_lo_d} = msub_res;
                            pend_we_d = 1'b1;
                            cnt_d     = MultLoad;
                            state_d   = StRun;
                        end
                        OpDiv: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quot_s;
                            pend_we_d = (B != 32'd0);
                            cnt_d     = DivLoad;
                            state_d   = StRun;
                        end
                        OpDivu: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quot_u;
                            pend_we_d = (B != 32'd0);
                            cnt_d     = DivLoad;
                            state_d   = StRun;
                        end
                        OpMthi:  hi_d = A;
                        OpMtlo:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // Start is ignored here; cancel wins over the final-edge commit.
                if (cancel) begin
                    pend_we_d = 1'b0;
                    cnt_d     = 4'd0;
                    state_d   = StIdle;
                end else if (cnt_q == 4'd1) begin
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    pend_we_d = 1'b0;
                    cnt_d     = 4'd0;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    // Busy rises in the issue cycle so the dependent D-stage instruction stalls at once.
    always_comb begin
        Busy = !reset && ((state_q == StRun) ||
                          (Start && (state_q == StIdle) && !cancel && is_multi));
        HI   = hi_q;
        LO   = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level behavioural model plus directed literals.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [2:0]  mdop = 3'd0;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_div_unit #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Start (start),
        .MDOp  (mdop),
        .A     (a_in),
        .B     (b_in),
`ifdef MDU_CANCEL_EN
        .Cancel(cancel),
`endif
        .Busy  (busy),
        .HI    (hi),
        .LO    (lo)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An issued op is "in flight" for cycles T+1..commit_at and lands at the end of commit_at.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    bit          m_pwe = 1'b0;
    int          cyc = 0;
    int          commit_at = -1;
    bit          chk_en = 1'b0;
    longint      m_ps;
    logic [63:0] m_pu;
    int          m_qa, m_qb;

    function automatic bit is_multi(logic [2:0] op);
        return (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd7);
    endfunction

    function automatic bit m_busy();
        return !reset && ((cyc <= commit_at) || (start && !cancel && is_multi(mdop)));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            commit_at = -1;
            chk_en = 1'b1;
        end else if (cyc <= commit_at) begin
            if (cancel) commit_at = -1;
            else if (cyc == commit_at && m_pwe) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start && !cancel) begin
            m_pwe = 1'b1;
            m_ps = longint'($signed(a_in)) * longint'($signed(b_in));
            case (mdop)
                3'd1: begin {m_phi, m_plo} = m_ps; commit_at = cyc + MC; end
                3'd2: begin
                    m_pu = {32'd0, a_in} * {32'd0, b_in};
                    {m_phi, m_plo} = m_pu;
                    commit_at = cyc + MC;
                end
                3'd7: begin
                    m_pu = {m_hi, m_lo} - 64'(m_ps);
                    {m_phi, m_plo} = m_pu;
                    commit_at = cyc + MC;
                end
                3'd3: begin
                    commit_at = cyc + DC;
                    if (b_in == 32'd0) m_pwe = 1'b0;
                    else if (a_in == 32'h8000_0000 && b_in == 32'hFFFF_FFFF) begin
                        m_plo = 32'h8000_0000;
                        m_phi = 32'd0;
                    end else begin
                        m_qa = $signed(a_in);
                        m_qb = $signed(b_in);
                        m_plo = m_qa / m_qb;
                        m_phi = m_qa % m_qb;
                    end
                end
                3'd4: begin
                    commit_at = cyc + DC;
                    if (b_in == 32'd0) m_pwe = 1'b0;
                    else begin
                        m_plo = a_in / b_in;
                        m_phi = a_in % b_in;
                    end
                end
                3'd5: m_hi = a_in;
                3'd6: m_lo = a_in;
                default: ;
            endcase
        end
        cyc++;
    end

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_busy()});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(bit s, logic [2:0] op, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        start = s;
        mdop = op;
        a_in = a;
        b_in = b;
    endtask

    // Call right after the issuing drive(); counts Busy cycles (bounded), then checks HI/LO.
    task automatic run_busy(string name, int exp_n, logic [31:0] exp_hi, logic [31:0] exp_lo);
        int n = 0;
        #2;
        for (int g = 0; g < 40 && busy; g++) begin
            n++;
            drive(1'b0, 3'd0, 32'd0, 32'd0);
            #2;
        end
        check({name, "_busy_cycles"}, n, exp_n);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        // mult -2 * 3
        drive(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
        run_busy("mult", MC + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // div -7 / 2, divu same operands
        drive(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
        run_busy("div", DC + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drive(1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2);
        run_busy("divu", DC + 1, 32'd1, 32'h7FFF_FFFC);

        // signed divide overflow
        drive(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_busy("div_ovf", DC + 1, 32'd0, 32'h8000_0000);

        // mthi / mtlo / msub
        drive(1'b1, 3'd5, 32'h10, 32'd0);
        drive(1'b1, 3'd6, 32'h20, 32'd0);
        drive(1'b1, 3'd7, 32'd2, 32'd3);
        run_busy("msub", MC + 1, 32'h10, 32'h1A);

        // divu by zero leaves HI/LO alone
        drive(1'b1, 3'd6, 32'h1234, 32'd0);
        drive(1'b1, 3'd4, 32'h5555, 32'd0);
        run_busy("divu_zero", DC + 1, 32'h10, 32'h1234);

        // reset discards an in-flight multu; Start during RUN is ignored
        drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 3'd5, 32'hDEAD, 32'd0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_flight_busy", {31'd0, busy}, 32'd0);
        check("rst_flight_hi", hi, 32'd0);
        check("rst_flight_lo", lo, 32'd0);
        repeat (12) drive(1'b0, 3'd0, 32'd0, 32'd0);
        #2;
        check("rst_flight_hi_late", hi, 32'd0);
        check("rst_flight_lo_late", lo, 32'd0);

`ifdef MDU_CANCEL_EN
        drive(1'b1, 3'd5, 32'h55, 32'd0);
        drive(1'b1, 3'd6, 32'h66, 32'd0);
        drive(1'b1, 3'd3, 32'd100, 32'd7);
        repeat (3) drive(1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        cancel = 1'b1;
        #2;
        check("cancel_busy_t4", {31'd0, busy}, 32'd1);
        @(negedge clk);
        cancel = 1'b0;
        #2;
        check("cancel_busy_t5", {31'd0, busy}, 32'd0);
        repeat (12) drive(1'b0, 3'd0, 32'd0, 32'd0);
        #2;
        check("cancel_hi", hi, 32'h55);
        check("cancel_lo", lo, 32'h66);
        @(negedge clk);
        start = 1'b1;
        mdop = 3'd5;
        a_in = 32'h99;
        cancel = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        cancel = 1'b0;
        #2;
        check("cancel_mthi", hi, 32'h55);
`endif

        // randomized phase, checked by the compare process
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 49) == 0);
            start = ($urandom_range(0, 2) != 0);
            mdop = 3'($urandom_range(0, 7));
            a_in = pick();
            b_in = pick();
`ifdef MDU_CANCEL_EN
            cancel = ($urandom_range(0, 29) == 0);
`endif
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        cancel = 1'b0;
        repeat (20) @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
